// File: rtl/mdu_core.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs mult/div over a fixed
// number of cycles and raises md_stall so the hazard unit holds MD-class ops in ID.
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Handshake: this unit initiates, the hazard unit responds. md_stall is high
  // in the start cycle of a mult/div and for every cycle busy is high; while it
  // is high no MD-class instruction may issue, so start never arrives in RUN.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_we;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_by_zero;
  logic        div_ovf;
  logic        is_md_long;

  assign is_md_long = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign md_stall   = (start && is_md_long) || busy;

  // The low 64 bits of a product of sign-extended operands is the signed product.
  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  assign div_by_zero = (src_b == 32'd0);
  assign div_ovf     = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  always_comb begin
    quot = 32'd0;
    rem  = 32'd0;
    if (!div_by_zero) begin
      if (md_op == OP_DIV) begin
        // INT_MIN / -1 wraps back to INT_MIN with a zero remainder, no trap.
        if (div_ovf) begin
          quot = 32'h8000_0000;
          rem  = 32'd0;
        end else begin
          quot = $unsigned($signed(src_a) / $signed(src_b));
          rem  = $unsigned($signed(src_a) % $signed(src_b));
        end
      end else begin
        quot = src_a / src_b;
        rem  = src_a % src_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (flush) begin
      // Kills any in-flight op and any start in the same cycle; HI/LO untouched.
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                pend_hi <= (md_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                pend_lo <= (md_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                pend_we <= 1'b1;
                cnt     <= MULT_LOAD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi <= rem;
                pend_lo <= quot;
                // Divide by zero still takes the full latency but never commits.
                pend_we <= !div_by_zero;
                cnt     <= DIV_LOAD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == CNT_ONE) begin
            if (pend_we) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            pend_we <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
